// File: rtl/fir_ahb_slave_pkg.sv
// ============================================================================
//  Module      : fir_ahb_pkg
//  Description : Shared constants, loader state type and byte-merge helper
//                for the FIR AHB-Lite slave front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_ahb_pkg;

  // htrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // Register map, expressed as halfword index (byte address >> 1)
  localparam logic [2:0] REG_STATUS    = 3'd0;  // 0x0
  localparam logic [2:0] REG_RESULT    = 3'd1;  // 0x2
  localparam logic [2:0] REG_SAMPLE    = 3'd2;  // 0x4
  localparam logic [2:0] REG_F0        = 3'd3;  // 0x6, F1..F3 follow at 0x8..0xC
  localparam logic [2:0] REG_NEW_COEFF = 3'd7;  // 0xE

  // Coefficient loader states
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_HOLD = 2'd2,
    LD_WAIT = 2'd3
  } loader_state_e;

  // Merge bus write data into an existing halfword honouring byte lanes:
  // even byte address -> low lane from wdata[7:0], odd -> high lane from wdata[15:8].
  function automatic logic [15:0] merge_write(input logic [15:0] old_val,
                                              input logic [15:0] wdata,
                                              input logic        byte_en,
                                              input logic        high_byte);
    logic [15:0] r;
    r = wdata;
    if (byte_en) begin
      if (high_byte) r = {wdata[15:8], old_val[7:0]};
      else           r = {old_val[15:8], wdata[7:0]};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_ahb_slave_if.sv
// ============================================================================
//  Module      : fir_ahb_slave_if
//  Description : AHB-Lite bus bundle between master and the FIR slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_ahb_slave_if;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;

  modport master (
    output hsel, haddr, hsize, htrans, hwrite, hwdata,
    input  hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, hsize, htrans, hwrite, hwdata,
    output hrdata, hresp
  );
endinterface

`default_nettype wire

// File: rtl/fir_ahb_slave_coefficient_loader.sv
// ============================================================================
//  Module      : coefficient_loader
//  Description : Sequences coefficients F0..F(N-1) into the filter one at a
//                time: LOAD pulse, two HOLD cycles for the filter's input
//                synchronizer, then WAIT until the filter drops modwait.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coefficient_loader
  import fir_ahb_pkg::*;
#(
  parameter int NUM_COEFF = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_i,
  input  logic        modwait_i,
  input  logic [15:0] coeff_i [NUM_COEFF],
  output logic        load_coeff_o,
  output logic [15:0] fir_coefficient_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int KW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NUM_COEFF - 1);

  loader_state_e state_q;
  logic [KW-1:0] k_q;
  logic          hold_q;
  logic          load_q;

  // Loader sequencer: state, coefficient index, hold counter and load strobe
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= LD_IDLE;
      k_q     <= '0;
      hold_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (start_i) begin
            state_q <= LD_LOAD;
            k_q     <= '0;
            load_q  <= 1'b1;
          end
        end
        LD_LOAD: begin
          state_q <= LD_HOLD;
          hold_q  <= 1'b0;
          load_q  <= 1'b0;
        end
        LD_HOLD: begin
          if (hold_q) state_q <= LD_WAIT;
          else        hold_q  <= 1'b1;
        end
        LD_WAIT: begin
          if (!modwait_i) begin
            if (k_q == LAST_K) begin
              state_q <= LD_IDLE;
              k_q     <= '0;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= LD_LOAD;
              load_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= LD_IDLE;
          load_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_coeff_o = load_q;
  assign busy_o       = (state_q != LD_IDLE);
  // Done is combinational so NEW_COEFF clears on the same edge the FSM
  // returns to IDLE, preventing an immediate restart.
  assign done_o       = (state_q == LD_WAIT) && !modwait_i && (k_q == LAST_K);

  // Coefficient register is read live so writes during a load take effect
  always_comb begin
    fir_coefficient_o = '0;
    if (state_q != LD_IDLE) fir_coefficient_o = coeff_i[k_q];
  end

endmodule

`default_nettype wire

// File: rtl/fir_ahb_slave.sv
// ============================================================================
//  Module      : fir_ahb_slave
//  Description : AHB-Lite register front end for the FIR filter: status,
//                result, sample and coefficient registers plus the sample
//                hand-off and coefficient loader control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_ahb_slave
  import fir_ahb_pkg::*;
#(
  parameter int NUM_COEFF = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  fir_ahb_slave_if.slave    bus,
  input  logic [15:0]       fir_out,
  input  logic              modwait,
  input  logic              err,
  output logic [15:0]       sample_data,
  output logic              data_ready,
  output logic [15:0]       fir_coefficient,
  output logic              load_coeff
);

  // Data-phase copies of the address-phase controls
  logic        dp_valid_q;
  logic        dp_write_q;
  logic [3:0]  dp_addr_q;
  logic [1:0]  dp_size_q;

  // Architectural registers
  logic [15:0] sample_q,  sample_d;
  logic        pending_q, pending_d;
  logic        new_coeff_q, new_coeff_d;
  logic [15:0] coeff_q [NUM_COEFF];
  logic [15:0] coeff_d [NUM_COEFF];

  logic                 addr_active;
  logic                 dp_wr;
  logic                 dp_rd;
  logic [2:0]           reg_idx;
  logic                 byte_hi;
  logic                 is_byte;
  logic                 sample_wr;
  logic [NUM_COEFF-1:0] coeff_we;
  logic                 loader_start;
  logic                 loader_busy;
  logic                 loader_done;

  assign addr_active = bus.hsel &&
                       ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));

  // Capture address-phase controls for use in the following data phase
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= '0;
    end else begin
      dp_valid_q <= addr_active;
      if (addr_active) begin
        dp_write_q <= bus.hwrite;
        dp_addr_q  <= bus.haddr;
        dp_size_q  <= bus.hsize;
      end
    end
  end

  assign dp_wr     = dp_valid_q && dp_write_q;
  assign dp_rd     = dp_valid_q && !dp_write_q;
  assign reg_idx   = dp_addr_q[3:1];
  assign byte_hi   = dp_addr_q[0];
  assign is_byte   = (dp_size_q == 2'd0);
  assign sample_wr = dp_wr && (reg_idx == REG_SAMPLE);

  // STATUS and RESULT are read-only; writing them is an error response
  assign bus.hresp = dp_wr && ((reg_idx == REG_STATUS) || (reg_idx == REG_RESULT));

  generate
    for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_coeff_we
      assign coeff_we[gi] = dp_wr && (reg_idx == 3'(REG_F0 + gi));
    end
  endgenerate

  // A pending sample has priority over starting a coefficient load
  assign data_ready   = pending_q && !loader_busy;
  assign loader_start = new_coeff_q && !modwait && !pending_q;

  // Next-state for registers written from the bus or by the loader
  always_comb begin
    sample_d    = sample_q;
    pending_d   = pending_q;
    new_coeff_d = new_coeff_q;
    coeff_d     = coeff_q;

    if (sample_wr) sample_d = merge_write(sample_q, bus.hwdata, is_byte, byte_hi);

    if (data_ready) pending_d = 1'b0;
    if (sample_wr)  pending_d = 1'b1;

    if (loader_done) begin
      new_coeff_d = 1'b0;
    end else if (dp_wr && (reg_idx == REG_NEW_COEFF) && !loader_busy) begin
      // Only bit0 is stored, so a high-byte write leaves it alone
      new_coeff_d = (is_byte && byte_hi) ? new_coeff_q : bus.hwdata[0];
    end

    for (int i = 0; i < NUM_COEFF; i++) begin
      if (coeff_we[i]) coeff_d[i] = merge_write(coeff_q[i], bus.hwdata, is_byte, byte_hi);
    end
  end

  // Register storage, updated at the end of the write data phase
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_q    <= '0;
      pending_q   <= 1'b0;
      new_coeff_q <= 1'b0;
      for (int i = 0; i < NUM_COEFF; i++) coeff_q[i] <= '0;
    end else begin
      sample_q    <= sample_d;
      pending_q   <= pending_d;
      new_coeff_q <= new_coeff_d;
      for (int i = 0; i < NUM_COEFF; i++) coeff_q[i] <= coeff_d[i];
    end
  end

  // Read mux driven from the registered address; zero outside a read data phase
  always_comb begin
    bus.hrdata = '0;
    if (dp_rd) begin
      case (reg_idx)
        REG_STATUS:    bus.hrdata = {7'd0, err, 7'd0, (modwait || loader_busy || pending_q)};
        REG_RESULT:    bus.hrdata = fir_out;
        REG_SAMPLE:    bus.hrdata = sample_q;
        REG_NEW_COEFF: bus.hrdata = {15'd0, new_coeff_q};
        default: begin
          for (int i = 0; i < NUM_COEFF; i++) begin
            if (reg_idx == 3'(REG_F0 + i)) bus.hrdata = coeff_q[i];
          end
        end
      endcase
    end
  end

  assign sample_data = sample_q;

  coefficient_loader #(
    .NUM_COEFF (NUM_COEFF)
  ) u_loader (
    .clk               (clk),
    .n_rst             (n_rst),
    .start_i           (loader_start),
    .modwait_i         (modwait),
    .coeff_i           (coeff_q),
    .load_coeff_o      (load_coeff),
    .fir_coefficient_o (fir_coefficient),
    .busy_o            (loader_busy),
    .done_o            (loader_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_fir_ahb_slave.sv
// ============================================================================
//  Module      : tb_fir_ahb_slave
//  Description : Directed testbench for fir_ahb_slave with a simple filter
//                model that holds modwait for three cycles per handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_ahb_slave;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] fir_out;
  logic        err;
  logic        modwait;
  logic [15:0] sample_data;
  logic        data_ready;
  logic [15:0] fir_coefficient;
  logic        load_coeff;

  fir_ahb_slave_if bus ();

  fir_ahb_slave #(.NUM_COEFF(4)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .bus             (bus),
    .fir_out         (fir_out),
    .modwait         (modwait),
    .err             (err),
    .sample_data     (sample_data),
    .data_ready      (data_ready),
    .fir_coefficient (fir_coefficient),
    .load_coeff      (load_coeff)
  );

  always #5 clk = ~clk;

  // Filter model: each load_coeff or data_ready strobe raises modwait for 3 cycles
  logic [1:0] mw_cnt;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)                        mw_cnt <= 2'd0;
    else if (load_coeff || data_ready) mw_cnt <= 2'd3;
    else if (mw_cnt != 2'd0)           mw_cnt <= mw_cnt - 2'd1;
  end
  assign modwait = (mw_cnt != 2'd0);

  // Event log sampled mid-cycle
  int          cyc = 0;
  int          dr_count = 0;
  int          dr_last = 0;
  int          lc_cyc[$];
  logic [15:0] lc_val[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (load_coeff) begin
      lc_cyc.push_back(cyc);
      lc_val.push_back(fir_coefficient);
    end
    if (data_ready) begin
      dr_count <= dr_count + 1;
      dr_last  <= cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [1:0] sz,
                           input logic [15:0] d, output logic resp);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'd2; bus.haddr = a; bus.hsize = sz; bus.hwrite = 1'b1;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'd0; bus.hwrite = 1'b0; bus.hwdata = d;
    #1 resp = bus.hresp;
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'd2; bus.haddr = a; bus.hsize = 2'd1; bus.hwrite = 1'b0;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'd0;
    #1 d = bus.hrdata;
  endtask

  task automatic wait_loads(input int n, input string tag);
    int i;
    i = 0;
    while (lc_cyc.size() < n && i < 200) begin
      @(negedge clk);
      i++;
    end
    check({tag, " load count"}, lc_cyc.size(), n);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;   // expected hrdata for reads, expected hresp for writes
  } vec_t;

  vec_t        vecs [16];
  logic        resp;
  logic [15:0] rd;
  int          dr0;

  initial begin
    // W/R, size, addr, wdata, expected
    vecs[0]  = '{1'b0, 2'd1, 4'h0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 2'd1, 4'h6, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b0, 2'd1, 4'h6, 16'h0000, 16'h1234};
    vecs[3]  = '{1'b1, 2'd0, 4'h7, 16'hABCD, 16'h0000};
    vecs[4]  = '{1'b0, 2'd1, 4'h6, 16'h0000, 16'hAB34};
    vecs[5]  = '{1'b1, 2'd0, 4'h8, 16'hFF56, 16'h0000};
    vecs[6]  = '{1'b0, 2'd1, 4'h8, 16'h0000, 16'h0056};
    vecs[7]  = '{1'b1, 2'd1, 4'hA, 16'hBEEF, 16'h0000};
    vecs[8]  = '{1'b0, 2'd1, 4'hA, 16'h0000, 16'hBEEF};
    vecs[9]  = '{1'b1, 2'd1, 4'h2, 16'h5555, 16'h0001};
    vecs[10] = '{1'b0, 2'd1, 4'h2, 16'h0000, 16'h7777};
    vecs[11] = '{1'b1, 2'd1, 4'h0, 16'h1111, 16'h0001};
    vecs[12] = '{1'b0, 2'd1, 4'h0, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 2'd1, 4'hC, 16'hCAFE, 16'h0000};
    vecs[14] = '{1'b1, 2'd3, 4'hC, 16'h1357, 16'h0000};
    vecs[15] = '{1'b0, 2'd1, 4'hC, 16'h0000, 16'h1357};

    bus.hsel = 1'b0; bus.htrans = 2'd0; bus.haddr = '0; bus.hsize = 2'd1;
    bus.hwrite = 1'b0; bus.hwdata = '0;
    fir_out = 16'h7777; err = 1'b0; n_rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst hrdata", bus.hrdata, 16'h0);
    check("rst hresp", bus.hresp, 1'b0);
    check("rst data_ready", data_ready, 1'b0);
    check("rst load_coeff", load_coeff, 1'b0);
    check("rst sample_data", sample_data, 16'h0);
    check("rst fir_coefficient", fir_coefficient, 16'h0);
    @(negedge clk) n_rst = 1'b1;

    // Table-driven register accesses
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        ahb_write(vecs[i].addr, vecs[i].size, vecs[i].wdata, resp);
        check($sformatf("vec%0d hresp", i), resp, vecs[i].exp[0]);
      end else begin
        ahb_read(vecs[i].addr, rd);
        check($sformatf("vec%0d hrdata", i), rd, vecs[i].exp);
      end
    end

    // Back-to-back write then read of the same register (SEQ second beat)
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'd2; bus.haddr = 4'h6; bus.hsize = 2'd1; bus.hwrite = 1'b1;
    @(negedge clk);
    bus.hwdata = 16'h4321; bus.htrans = 2'd3; bus.hwrite = 1'b0;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'd0;
    #1 check("forward read", bus.hrdata, 16'h4321);

    // Sample write while the loader is idle
    dr0 = dr_count;
    ahb_write(4'h4, 2'd1, 16'h0042, resp);
    @(negedge clk);
    #1;
    check("sample data_ready", data_ready, 1'b1);
    check("sample_data", sample_data, 16'h0042);
    ahb_read(4'h0, rd);
    check("status busy", rd, 16'h0001);
    repeat (4) @(negedge clk);
    ahb_read(4'h0, rd);
    check("status idle", rd, 16'h0000);
    ahb_read(4'h4, rd);
    check("sample readback", rd, 16'h0042);
    check("sample pulse count", dr_count - dr0, 1);

    // Full coefficient load, with writes during the load
    ahb_write(4'h6, 2'd1, 16'd1, resp);
    ahb_write(4'h8, 2'd1, 16'd2, resp);
    ahb_write(4'hA, 2'd1, 16'd3, resp);
    ahb_write(4'hC, 2'd1, 16'd4, resp);
    lc_cyc.delete(); lc_val.delete();
    ahb_write(4'hE, 2'd1, 16'h0001, resp);
    ahb_read(4'hE, rd);
    check("new_coeff set", rd, 16'h0001);
    ahb_write(4'hE, 2'd1, 16'h0000, resp);
    ahb_read(4'hE, rd);
    check("new_coeff write ignored", rd, 16'h0001);
    ahb_write(4'hC, 2'd1, 16'h0044, resp);
    wait_loads(4, "coef");
    repeat (8) @(negedge clk);
    check("coef total pulses", lc_cyc.size(), 4);
    if (lc_cyc.size() >= 4) begin
      check("coef0", lc_val[0], 16'd1);
      check("coef1", lc_val[1], 16'd2);
      check("coef2", lc_val[2], 16'd3);
      check("coef3 live update", lc_val[3], 16'h0044);
      for (int i = 1; i < 4; i++)
        check($sformatf("coef spacing%0d", i), lc_cyc[i] - lc_cyc[i-1], 5);
    end
    ahb_read(4'hE, rd);
    check("new_coeff cleared", rd, 16'h0000);

    // Sample written during a load is held until the loader is idle
    dr0 = dr_count;
    lc_cyc.delete(); lc_val.delete();
    ahb_write(4'hE, 2'd1, 16'h0001, resp);
    ahb_write(4'h4, 2'd1, 16'h0099, resp);
    wait_loads(4, "deferred");
    repeat (10) @(negedge clk);
    check("deferred pulse count", dr_count - dr0, 1);
    if (lc_cyc.size() >= 4) check("deferred pulse cycle", dr_last - lc_cyc[3], 5);
    check("deferred sample_data", sample_data, 16'h0099);

    // Sample and load start in the same idle window: sample goes first
    dr0 = dr_count;
    lc_cyc.delete(); lc_val.delete();
    ahb_write(4'h4, 2'd1, 16'h00AA, resp);
    ahb_write(4'hE, 2'd1, 16'h0001, resp);
    wait_loads(1, "priority");
    check("priority pulse count", dr_count - dr0, 1);
    if (lc_cyc.size() >= 1) check("priority order", lc_cyc[0] > dr_last, 1'b1);
    wait_loads(4, "priority full");
    repeat (8) @(negedge clk);

    // Filter error reflected in STATUS
    err = 1'b1;
    ahb_read(4'h0, rd);
    check("status err", rd, 16'h0100);
    err = 1'b0;

    // Asynchronous reset in the middle of a load
    ahb_write(4'hE, 2'd1, 16'h0001, resp);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst fir_coefficient", fir_coefficient, 16'h0);
    check("midrst load_coeff", load_coeff, 1'b0);
    @(negedge clk) n_rst = 1'b1;
    ahb_read(4'hE, rd);
    check("midrst new_coeff", rd, 16'h0000);
    ahb_read(4'h6, rd);
    check("midrst F0", rd, 16'h0000);
    check("midrst sample_data", sample_data, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
